muldiv_unit: RTL and testbench

//  Multi-cycle integer multiply/divide unit with architectural HI/LO registers.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               accept;
    logic               mt_write;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign accept   = (state == IDLE) && start && !op[2];
    assign mt_write = (state == IDLE) && start && (op[2:1] == 2'b10);

    // Signed ops use magnitudes; an unsigned WIDTH-bit magnitude already holds
    // 2^(WIDTH-1), so the most-negative operand needs no extra bit.
    assign a_neg = !op[0] && a[WIDTH-1];
    assign b_neg = !op[0] && b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: remainder never reaches the divisor, so the trial
    // difference fits in WIDTH+1 bits and its top bit is the borrow.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
    assign div_ok    = !div_trial[WIDTH];
    assign div_next  = div_ok ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {acc[2*WIDTH-2:0], 1'b0};

    // Sign correction. A zero divisor yields quotient all ones and a remainder
    // equal to |a|, which the dividend-sign rule turns back into a.
    assign prod   = neg_res ? (~acc + 1'b1) : acc;
    assign quo    = acc[WIDTH-1:0];
    assign rem    = acc[2*WIDTH-1:WIDTH];
    assign fix_lo = !is_div ? prod[WIDTH-1:0]
                  : div_zero ? {WIDTH{1'b1}}
                  : neg_res  ? (~quo + 1'b1) : quo;
    assign fix_hi = !is_div ? prod[2*WIDTH-1:WIDTH]
                  : neg_rem  ? (~rem + 1'b1) : rem;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (cnt == CNT_LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (accept) begin
                acc      <= {{WIDTH{1'b0}}, a_mag};
                opb      <= b_mag;
                cnt      <= '0;
                is_div   <= op[1];
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (b == '0);
            end else if (state == RUN) begin
                acc <= is_div ? div_next : mul_next;
                cnt <= cnt + 1'b1;
            end

            if (state == FIX) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (mt_write) begin
                if (op[0]) begin
                    lo_q <= a;
                end else begin
                    hi_q <= a;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        logic [63:0] p;
        p  = '0;
        eh = '0;
        el = '0;
        case (o)
            3'd0: begin
                p  = longint'($signed(x)) * longint'($signed(y));
                eh = p[63:32];
                el = p[31:0];
            end
            3'd1: begin
                p  = {32'b0, x} * {32'b0, y};
                eh = p[63:32];
                el = p[31:0];
            end
            3'd2: begin
                if (y == 0) begin
                    eh = x;
                    el = '1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    eh = '0;
                    el = x;
                end else begin
                    el = $signed(x) / $signed(y);
                    eh = $signed(x) % $signed(y);
                end
            end
            default: begin
                if (y == 0) begin
                    eh = x;
                    el = '1;
                end else begin
                    el = x / y;
                    eh = x % y;
                end
            end
        endcase
    endfunction

    // Waits for done (first sampled cycle after the start edge is cyc=1),
    // checks latency, busy length, HI/LO stability, then pops the scoreboard.
    task automatic finish_op(input string name, input int inj,
                             input logic [W-1:0] old_hi, input logic [W-1:0] old_lo);
        int cyc;
        int busy_cnt;
        bit moved;
        exp_t e;
        cyc = 1;
        busy_cnt = 0;
        moved = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cnt++;
            if (hi !== old_hi || lo !== old_lo) moved = 1;
            if (inj != 0 && cyc == inj) begin
                start = 1'b1;
                op = 3'b011;
                a = 32'd1;
                b = 32'd1;
            end else if (inj != 0 && cyc == inj + 1) begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (busy) busy_cnt++;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done never rose within %0d cycles", name, cyc);
        end
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT);
        end
        checks++;
        if (busy_cnt !== LAT) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, LAT);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL %s hilo_hold: HI/LO changed before done, old hi=%h lo=%h", name, old_hi, old_lo);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: empty on done", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e.hi, e.lo);
            end
        end
    endtask

    task automatic issue_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                            input int inj);
        logic [W-1:0] oh;
        logic [W-1:0] ol;
        oh = hi;
        ol = lo;
        sb.push_back('{hi: eh, lo: el});
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        start = 1'b0;
        finish_op(name, inj, oh, ol);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op = 3'b000;
        a = '0;
        b = '0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        issue_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        issue_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        issue_op("mult_min",  3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    endtask

    task automatic test_div();
        issue_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        issue_op("divu_7_2",  3'b011, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0);
        issue_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        issue_op("divu_zero", 3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        issue_op("div_zero",  3'b010, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom();
            y = (i % 3 == 2) ? 32'($urandom_range(1, 20)) : $urandom();
            if (i == 5) y = 32'hFFFF_FFFF - 32'd4;
            model(o, x, y, eh, el);
            issue_op("random", o, x, y, eh, el, 0);
        end
    endtask

    task automatic test_mt();
        logic [W-1:0] ol;
        logic [W-1:0] oh;
        ol = lo;
        start = 1'b1;
        op = 3'b100;
        a = 32'h0000_CAFE;
        tick();
        start = 1'b0;
        checks++;
        if (hi !== 32'h0000_CAFE || lo !== ol || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b want hi=0000cafe lo=%h 0 0", hi, lo, busy, done, ol);
        end
        start = 1'b1;
        op = 3'b101;
        a = 32'h1357_9BDF;
        tick();
        start = 1'b0;
        checks++;
        if (lo !== 32'h1357_9BDF || hi !== 32'h0000_CAFE || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b want hi=0000cafe lo=13579bdf 0 0", hi, lo, busy, done);
        end
        oh = hi;
        ol = lo;
        start = 1'b1;
        op = 3'b110;
        a = 32'h5555_5555;
        b = 32'h3;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || hi !== oh || lo !== ol) begin
            errors++;
            $display("FAIL reserved_op: got busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, oh, ol);
        end
    endtask

    task automatic test_busy_ignore();
        issue_op("divu_busy_start", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 5);
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL busy_ignore_tail: got busy=%b hi=%h lo=%h want 0 2 e", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oh;
        logic [W-1:0] ol;
        oh = hi;
        ol = lo;
        sb.push_back('{hi: 32'h0, lo: 32'd391});
        start = 1'b1;
        op = 3'b001;
        a = 32'd17;
        b = 32'd23;
        tick();
        start = 1'b0;
        finish_op("b2b_first", 0, oh, ol);
        start = 1'b1;
        op = 3'b011;
        a = 32'd50;
        b = 32'd6;
        sb.push_back('{hi: 32'd2, lo: 32'd8});
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b want 0", busy);
        end
        oh = hi;
        ol = lo;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_done: got busy=%b want 1", busy);
        end
        finish_op("b2b_second", 0, oh, ol);
        tick();
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        start = 1'b1;
        op = 3'b001;
        a = 32'hFFFF_FFFF;
        b = 32'h0001_2345;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) saw_done = 1;
            tick();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_quiet: got activity after abort want none");
        end
        issue_op("multu_after_reset", 3'b001, 32'd3, 32'd5, 32'h0, 32'hF, 0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mt();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
